alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, operand/result width.
- TAG_WIDTH, 4, requester-supplied transaction tag width.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- reqN_valid  in  1  requester N (N=0,1) operation valid.
- reqN_ready  out  1  requester N operation accepted this cycle.
- reqN_aluop  in  4  ALU opcode (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB, SRA per defines.v).
- reqN_a  in  DATA_WIDTH  operand 1.
- reqN_b  in  DATA_WIDTH  operand 2.
- reqN_tag  in  TAG_WIDTH  tag, returned unchanged with result.
- rspN_valid  out  1  result for requester N held.
- rspN_ready  in  1  requester N consumes result.
- rspN_data  out  DATA_WIDTH  registered ALU result.
- rspN_tag  out  TAG_WIDTH  tag of that result.
- ops_count  out  16  total accepted operations, saturating.

Function
REQ-003 Block SHALL contain exactly one ALU instance shared by both requesters; operands/opcode of the granted requester drive it.
REQ-004 Requester N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-005 At most one grant per cycle; reqN_ready=1 only for the granted requester, and only when eligible; reqN_ready MAY depend combinationally on both reqX_valid and rspX_ready.
REQ-006 One requester eligible: it SHALL be granted.
REQ-007 Both eligible: requester indicated by 1-bit round-robin pointer rr SHALL be granted.
REQ-008 After any grant, rr SHALL point to the non-granted requester; with no grant, rr SHALL hold.
REQ-009 Accept (reqN_valid & reqN_ready) SHALL register ALU result into rspN_data and reqN_tag into rspN_tag, and set rspN_valid=1 on the next edge; latency exactly 1 cycle.
REQ-010 rspN_valid/data/tag SHALL hold stable until rspN_valid & rspN_ready.
REQ-011 Drain without new accept for N: rspN_valid SHALL go 0 next edge; rspN_data/tag hold last value.
REQ-012 Drain and accept for N in same cycle: rspN_valid SHALL stay 1 and data/tag update to the new result (back-to-back throughput 1 op/cycle).
REQ-013 Result slots SHALL be independent: a stalled rsp0 SHALL NOT block requester 1, and vice versa.
REQ-014 Unknown opcode SHALL produce result 0 and still complete normally.
REQ-015 ops_count SHALL increment by 1 per accept, saturating at 16'hFFFF.
REQ-016 Starvation bound: a continuously eligible requester SHALL be granted within 2 cycles.
REQ-017 No combinational path SHALL exist from reqN inputs to rspN outputs.

Reset
REQ-018 While rst=1 at an edge: rsp0_valid=rsp1_valid=0, rspN_data=0, rspN_tag=0, rr=0, ops_count=0.
REQ-019 While rst=1, req0_ready=req1_ready=0; no operation accepted.
REQ-020 Reset asserted mid-operation SHALL discard held results without a response handshake; first cycle after deassertion behaves as after power-up.

Verification
REQ-021 Single op: req0 ADD a=5 b=7 tag=3, rsp0_ready=1 -> next cycle rsp0_valid=1, rsp0_data=12, rsp0_tag=3; ops_count=1.
REQ-022 Contention: both valid every cycle, rsp ready=1, after reset -> grants alternate 0,1,0,1; each rsp valid every other cycle.
REQ-023 Backpressure: rsp0_ready=0, req0 SUB 10-3 then second op -> rsp0_data=7 held, req0_ready=0 while req1 still granted every cycle.
REQ-024 Simultaneous drain+accept: rsp0_valid=1, rsp0_ready=1, req0 XOR FF^0F -> rsp0_valid stays 1, data=F0.
REQ-025 Reset mid-flight: rsp1_valid=1 held, assert rst one cycle -> rsp1_valid=0, ops_count=0, rr=0; both valid next -> req0 granted.
REQ-026 Saturation: force 65536 accepts -> ops_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU: round-robin grant on contention,
// plus an independent registered result slot per requester with valid/ready drain.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_aluop,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [TAG_WIDTH-1:0]  req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_aluop,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [TAG_WIDTH-1:0]  req1_tag,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic [TAG_WIDTH-1:0]  rsp0_tag,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic [TAG_WIDTH-1:0]  rsp1_tag,
    output logic [15:0]           ops_count
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLT  = 4'h2;
    localparam logic [3:0] OP_SLTU = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_SUB  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'hD;

    function automatic logic [DATA_WIDTH-1:0] alu_f(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic [SHAMT_W-1:0]           sh;
        logic [DATA_WIDTH-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = sa >>> sh;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                  rsp0_valid_q, rsp0_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q,  rsp0_data_d;
    logic [TAG_WIDTH-1:0]  rsp0_tag_q,   rsp0_tag_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q,  rsp1_data_d;
    logic [TAG_WIDTH-1:0]  rsp1_tag_q,   rsp1_tag_d;
    logic                  rr_q,         rr_d;
    logic [15:0]           ops_q,        ops_d;

    logic                  elig0, elig1, gnt0, gnt1;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_res;

    // A slot can take a new result if it is empty or being drained this cycle.
    assign elig0 = req0_valid & (~rsp0_valid_q | rsp0_ready);
    assign elig1 = req1_valid & (~rsp1_valid_q | rsp1_ready);
    assign gnt0  = ~rst & elig0 & (~elig1 | ~rr_q);
    assign gnt1  = ~rst & elig1 & (~elig0 | rr_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign alu_op  = gnt1 ? req1_aluop : req0_aluop;
    assign alu_a   = gnt1 ? req1_a     : req0_a;
    assign alu_b   = gnt1 ? req1_b     : req0_b;
    assign alu_res = alu_f(alu_op, alu_a, alu_b);

    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp0_tag_d   = rsp0_tag_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        rsp1_tag_d   = rsp1_tag_q;
        rr_d         = rr_q;
        ops_d        = ops_q;

        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_res;
            rsp0_tag_d   = req0_tag;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_res;
            rsp1_tag_d   = req1_tag;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end

        if (gnt0) begin
            rr_d = 1'b1;
        end else if (gnt1) begin
            rr_d = 1'b0;
        end

        if (gnt0 | gnt1) begin
            ops_d = sat_inc(ops_q);
        end
    end

    // Result stage: everything visible on rsp* comes straight from these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_tag_q   <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_tag_q   <= '0;
            rr_q         <= 1'b0;
            ops_q        <= '0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_tag_q   <= rsp0_tag_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_tag_q   <= rsp1_tag_d;
            rr_q         <= rr_d;
            ops_q        <= ops_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp0_tag   = rsp0_tag_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp1_tag   = rsp1_tag_q;
    assign ops_count  = ops_q;

endmodule
